c8_count_sched: RTL



---
 rtl/c8_sched_pkg.sv | 13 +
 rtl/c8_rr_arb.sv | 40 ++++
 rtl/c8_count_sched.sv | 114 +++++++++++
 3 files changed

// File: rtl/c8_sched_pkg.sv
// Shared types and constants for the c8 count scheduler.
package c8_sched_pkg;

  localparam int C8_NREQ  = 2;
  localparam int C8_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } c8_sched_state_t;

endpackage

// File: rtl/c8_rr_arb.sv
// Two-way round-robin arbiter: combinational grant while enabled,
// registered priority pointer that moves past the winner on each accept.
module c8_rr_arb
  import c8_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [C8_NREQ-1:0] valid,
  output logic [C8_NREQ-1:0] grant,
  output logic               accept,
  output logic               grant_id
);

  logic ptr_reg;

  always_comb begin
    grant = '0;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_reg ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  assign accept   = |(valid & grant);
  assign grant_id = grant[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= 1'b0;
    end else if (accept) begin
      ptr_reg <= ~grant_id;
    end
  end

endmodule

// File: rtl/c8_count_sched.sv
// Shares a loadable down-counter between two requesters and reports completion.
// Optional cancel support is compiled in with C8_SCHED_ABORT_EN.
module c8_count_sched
  import c8_sched_pkg::*;
#(
  parameter int WIDTH = C8_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [C8_NREQ-1:0]         req_valid,
  input  logic [C8_NREQ*WIDTH-1:0]   req_data,
  output logic [C8_NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           cnt_q,
  output logic                       busy,
  output logic                       done,
`ifdef C8_SCHED_ABORT_EN
  input  logic                       abort,
  output logic                       done_abort,
`endif
  output logic                       done_id
);

  c8_sched_state_t  state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             done_id_reg, done_id_next;
  logic             done_reg, busy_reg;
  logic             accept, grant_id, abort_hit;
  logic [WIDTH-1:0] req_word [C8_NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < C8_NREQ; gi++) begin : g_slice
      assign req_word[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  c8_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .en       (state_reg == IDLE),
    .valid    (req_valid),
    .grant    (req_ready),
    .accept   (accept),
    .grant_id (grant_id)
  );

`ifdef C8_SCHED_ABORT_EN
  logic done_abort_reg;
  assign abort_hit  = abort && (state_reg == COUNT);
  assign done_abort = done_abort_reg;
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    done_id_next = done_id_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next     = req_word[grant_id];
          done_id_next = grant_id;
          state_next   = (req_word[grant_id] != '0) ? COUNT : DONE;
        end
      end
      COUNT: begin
        // Abort freezes the counter, even on its final step.
        if (abort_hit) begin
          state_next = DONE;
        end else if (cnt_reg > WIDTH'(1)) begin
          cnt_next = cnt_reg - WIDTH'(1);
        end else begin
          cnt_next   = '0;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      done_id_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      done_id_reg <= done_id_next;
      done_reg    <= (state_next == DONE);
      busy_reg    <= (state_next != IDLE);
    end
  end

`ifdef C8_SCHED_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      done_abort_reg <= 1'b0;
    end else begin
      done_abort_reg <= abort_hit;
    end
  end
`endif

  assign cnt_q   = cnt_reg;
  assign done    = done_reg;
  assign done_id = done_id_reg;
  assign busy    = busy_reg;

endmodule
